// File: rtl/mpa_dbg_pkg.sv
// Shared encodings for the MIPS debug-port bridge: header fields, FSM states
// and address stepping constants.
package mpa_dbg_pkg;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_RELEASE = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    FN_IM      = 2'b00,
    FN_DM      = 2'b01,
    FN_MR      = 2'b10,
    FN_ILLEGAL = 2'b11
  } func_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CNT,
    ST_WDAT,
    ST_WSTB,
    ST_RREQ,
    ST_RCAP,
    ST_RSND
  } state_e;

  localparam int ADDR_STEP_BYTE = 4;
  localparam int ADDR_STEP_WORD = 1;
  localparam int ADDR_BYTES     = 4;

  function automatic logic hdr_legal(input logic [7:0] hdr);
    return (hdr[7:6] != OP_ILLEGAL) && (hdr[5:4] != FN_ILLEGAL);
  endfunction

endpackage

// File: rtl/mpa_dbg_byte_shifter.sv
// NB-byte shift register: assembles a word from LSB-first bytes, or takes a
// parallel word and shifts it out LSB-first. `done` marks the final byte.
module mpa_dbg_byte_shifter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [7:0]            byte_in,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] word_nxt,
  output logic [7:0]            byte_out,
  output logic                  done
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  assign done     = (cnt_q == CW'(NB - 1));
  assign byte_out = word_q[7:0];
  assign word_nxt = word_d;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    word_d = word_q;
    cnt_d  = cnt_q;
    if (load) begin
      word_d = word_in;
    end else if (push) begin
      word_d = (word_q >> 8) | (DATA_WIDTH'(byte_in) << (DATA_WIDTH - 8));
    end else if (pop) begin
      word_d = word_q >> 8;
    end
    if (push || pop) begin
      cnt_d = done ? '0 : cnt_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mpa_debug_bridge.sv
// Command byte stream to mpa_mips_32 debug port: burst writes/reads into
// IM, DM or MR, read data returned as an LSB-first byte stream.
module mpa_debug_bridge
  import mpa_dbg_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     HW_RSTn,
  input  logic                     s_valid,
  input  logic [7:0]               s_data,
  output logic                     s_ready,
  output logic                     m_valid,
  output logic [7:0]               m_data,
  input  logic                     m_ready,
  output logic                     mem_debug,
  output logic [1:0]               debug_func,
  output logic                     debug_we,
  output logic                     debug_re,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0]    din,
  input  logic [DATA_WIDTH-1:0]    dout,
  output logic                     busy,
  output logic                     err
);

  state_e                   state_q, state_d;
  logic                     live_q, live_d;
  logic [1:0]               abyte_q, abyte_d;
  logic [ADDR_BYTES*8-1:0]  ash_q, ash_d;
  logic [7:0]               words_q, words_d;
  logic                     rd_q, rd_d;
  logic                     mem_debug_q, mem_debug_d;
  logic [1:0]               func_q, func_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    din_q, din_d;
  logic                     err_q, err_d;

  logic                     s_fire, m_fire;
  logic                     sh_push, sh_load, sh_pop, sh_done;
  logic [DATA_WIDTH-1:0]    sh_word_nxt;
  logic [7:0]               sh_byte;
  logic [ADDRESS_WIDTH-1:0] addr_step;

  mpa_dbg_byte_shifter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shifter (
    .clk      (CLK),
    .rst_n    (HW_RSTn),
    .push     (sh_push),
    .byte_in  (s_data),
    .load     (sh_load),
    .word_in  (dout),
    .pop      (sh_pop),
    .word_nxt (sh_word_nxt),
    .byte_out (sh_byte),
    .done     (sh_done)
  );

  // live_q keeps s_ready low until the first clock after reset release.
  assign s_ready = live_q && (state_q inside {ST_IDLE, ST_ADDR, ST_CNT, ST_WDAT});
  assign m_valid = (state_q == ST_RSND);
  assign m_data  = m_valid ? sh_byte : 8'h00;
  assign s_fire  = s_valid && s_ready;
  assign m_fire  = m_valid && m_ready;

  assign debug_we   = (state_q == ST_WSTB);
  assign debug_re   = (state_q == ST_RREQ);
  assign busy       = (state_q != ST_IDLE);
  assign mem_debug  = mem_debug_q;
  assign debug_func = func_q;
  assign addr       = addr_q;
  assign din        = din_q;
  assign err        = err_q;

  assign addr_step = (func_q == FN_MR) ? ADDRESS_WIDTH'(ADDR_STEP_WORD)
                                       : ADDRESS_WIDTH'(ADDR_STEP_BYTE);

  always_comb begin
    state_d     = state_q;
    live_d      = 1'b1;
    abyte_d     = abyte_q;
    ash_d       = ash_q;
    words_d     = words_q;
    rd_d        = rd_q;
    mem_debug_d = mem_debug_q;
    func_d      = func_q;
    addr_d      = addr_q;
    din_d       = din_q;
    err_d       = 1'b0;
    sh_push     = 1'b0;
    sh_load     = 1'b0;
    sh_pop      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (s_fire) begin
          if (!hdr_legal(s_data)) begin
            err_d = 1'b1;
          end else if (s_data[7:6] == OP_RELEASE) begin
            if (mem_debug_q) begin
              mem_debug_d = 1'b0;
              func_d      = '0;
              addr_d      = '0;
              din_d       = '0;
            end
          end else begin
            mem_debug_d = 1'b1;
            func_d      = s_data[5:4];
            rd_d        = (s_data[7:6] == OP_READ);
            abyte_d     = '0;
            state_d     = ST_ADDR;
          end
        end
      end

      ST_ADDR: begin
        if (s_fire) begin
          ash_d   = {s_data, ash_q[ADDR_BYTES*8-1:8]};
          abyte_d = abyte_q + 2'd1;
          if (abyte_q == 2'(ADDR_BYTES - 1)) state_d = ST_CNT;
        end
      end

      ST_CNT: begin
        if (s_fire) begin
          // A count byte of 0 wraps through 255..1, giving 256 words.
          words_d = s_data;
          addr_d  = ash_q[ADDRESS_WIDTH-1:0];
          state_d = rd_q ? ST_RREQ : ST_WDAT;
        end
      end

      ST_WDAT: begin
        if (s_fire) begin
          sh_push = 1'b1;
          if (sh_done) begin
            din_d   = sh_word_nxt;
            state_d = ST_WSTB;
          end
        end
      end

      ST_WSTB: begin
        addr_d  = addr_q + addr_step;
        words_d = words_q - 8'd1;
        state_d = (words_q == 8'd1) ? ST_IDLE : ST_WDAT;
      end

      ST_RREQ: state_d = ST_RCAP;

      ST_RCAP: begin
        sh_load = 1'b1;
        state_d = ST_RSND;
      end

      ST_RSND: begin
        if (m_fire) begin
          sh_pop = 1'b1;
          if (sh_done) begin
            addr_d  = addr_q + addr_step;
            words_d = words_q - 8'd1;
            state_d = (words_q == 8'd1) ? ST_IDLE : ST_RREQ;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge HW_RSTn) begin
    if (!HW_RSTn) begin
      state_q     <= ST_IDLE;
      live_q      <= 1'b0;
      abyte_q     <= '0;
      ash_q       <= '0;
      words_q     <= '0;
      rd_q        <= 1'b0;
      mem_debug_q <= 1'b0;
      func_q      <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      live_q      <= live_d;
      abyte_q     <= abyte_d;
      ash_q       <= ash_d;
      words_q     <= words_d;
      rd_q        <= rd_d;
      mem_debug_q <= mem_debug_d;
      func_q      <= func_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_mpa_debug_bridge.sv
// Scoreboard bench for mpa_debug_bridge: a core memory model answers the
// debug port; expected strobes and response bytes are queued per command.
module tb_mpa_debug_bridge;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NB = DW / 8;

  logic          CLK = 1'b0;
  logic          HW_RSTn = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_ready;
  logic          m_valid;
  logic [7:0]    m_data;
  logic          m_ready = 1'b1;
  logic          mem_debug;
  logic [1:0]    debug_func;
  logic          debug_we, debug_re;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout = '0;
  logic          busy, err;

  always #5 CLK = ~CLK;

  mpa_debug_bridge #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .CLK(CLK), .HW_RSTn(HW_RSTn),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .mem_debug(mem_debug), .debug_func(debug_func),
    .debug_we(debug_we), .debug_re(debug_re),
    .addr(addr), .din(din), .dout(dout),
    .busy(busy), .err(err)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         we_q[$];
  logic [31:0] re_q[$];
  logic [7:0]  byte_q[$];
  logic [31:0] wr_data[$];
  logic [31:0] ref_mem  [bit [33:0]];
  logic [31:0] core_mem [bit [33:0]];

  int checks = 0, errors = 0;
  int we_cnt = 0, re_cnt = 0, err_cnt = 0, bytes_seen = 0, re_age = 0;
  bit expect_mv = 1'b0;
  wr_t exp_w;
  logic [31:0] exp_a;
  logic [7:0]  exp_b;

  // Core model: synchronous write, registered read.
  always @(posedge CLK) begin
    if (debug_we) core_mem[{debug_func, addr}] = din;
    if (debug_re) dout <= core_mem.exists({debug_func, addr}) ? core_mem[{debug_func, addr}] : '0;
  end

  // Monitor: samples on the falling edge, pops the scoreboard on each DUT event.
  always @(negedge CLK) begin
    if (HW_RSTn) begin
      if (debug_we || debug_re) begin
        checks++;
        if (debug_we && debug_re) begin
          errors++;
          $display("FAIL we_re_overlap got=both expected=exclusive");
        end
      end
      if (debug_we) begin
        we_cnt++;
        checks++;
        if (we_q.size() == 0) begin
          errors++;
          $display("FAIL we_unexpected addr=%h din=%h expected=none", addr, din);
        end else begin
          exp_w = we_q.pop_front();
          if ({addr, din} !== {exp_w.a, exp_w.d}) begin
            errors++;
            $display("FAIL we_strobe got addr=%h din=%h expected addr=%h din=%h",
                     addr, din, exp_w.a, exp_w.d);
          end
        end
      end
      if (debug_re) begin
        re_cnt++;
        checks++;
        re_age    = 0;
        expect_mv = 1'b1;
        if (re_q.size() == 0) begin
          errors++;
          $display("FAIL re_unexpected addr=%h expected=none", addr);
        end else begin
          exp_a = re_q.pop_front();
          if (addr !== exp_a) begin
            errors++;
            $display("FAIL re_addr got=%h expected=%h", addr, exp_a);
          end
        end
      end else if (expect_mv) begin
        re_age++;
      end
      if (m_valid && expect_mv) begin
        checks++;
        expect_mv = 1'b0;
        if (re_age != 2) begin
          errors++;
          $display("FAIL first_m_valid_latency got=%0d expected=2", re_age);
        end
      end
      if (m_valid && m_ready) begin
        bytes_seen++;
        checks++;
        if (byte_q.size() == 0) begin
          errors++;
          $display("FAIL byte_unexpected got=%h expected=none", m_data);
        end else begin
          exp_b = byte_q.pop_front();
          if (m_data !== exp_b) begin
            errors++;
            $display("FAIL m_data got=%h expected=%h", m_data, exp_b);
          end
        end
      end
      if (err) err_cnt++;
    end
  end

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    int   t;
    t       = 0;
    s_valid = 1'b1;
    s_data  = b;
    do begin
      @(negedge CLK);
      rdy = s_ready;
      sync();
      t++;
    end while (!rdy && t < 2000);
    s_valid = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout byte=%h got=0 expected=1", b);
    end
  endtask

  task automatic send_cmd(input logic [7:0] hdr, input logic [31:0] a, input logic [7:0] n);
    send_byte(hdr);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    send_byte(n);
  endtask

  function automatic logic [31:0] step_of(input logic [1:0] fn);
    return (fn == 2'b10) ? 32'd1 : 32'd4;
  endfunction

  task automatic do_write(input logic [1:0] fn, input logic [31:0] a, input logic [7:0] n);
    int          words;
    logic [31:0] cur;
    words = (n == 8'd0) ? 256 : int'(n);
    cur   = a;
    for (int w = 0; w < words; w++) begin
      we_q.push_back({cur, wr_data[w]});
      ref_mem[{fn, cur}] = wr_data[w];
      cur += step_of(fn);
    end
    send_cmd({2'b00, fn, 4'h0}, a, n);
    for (int w = 0; w < words; w++)
      for (int b = 0; b < NB; b++) send_byte(wr_data[w][8*b +: 8]);
  endtask

  task automatic do_read(input logic [1:0] fn, input logic [31:0] a, input logic [7:0] n);
    int          words;
    logic [31:0] cur, v;
    words = (n == 8'd0) ? 256 : int'(n);
    cur   = a;
    for (int w = 0; w < words; w++) begin
      v = ref_mem.exists({fn, cur}) ? ref_mem[{fn, cur}] : 32'h0;
      re_q.push_back(cur);
      for (int b = 0; b < NB; b++) byte_q.push_back(v[8*b +: 8]);
      cur += step_of(fn);
    end
    send_cmd({2'b01, fn, 4'h0}, a, n);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((we_q.size() != 0 || re_q.size() != 0 || byte_q.size() != 0 || busy) && t < 8000) begin
      @(negedge CLK);
      t++;
    end
    checks++;
    if (t >= 8000) begin
      errors++;
      $display("FAIL %s_drain got we=%0d re=%0d bytes=%0d busy=%b expected=all empty",
               name, we_q.size(), re_q.size(), byte_q.size(), busy);
    end
    sync();
  endtask

  task automatic test_reset();
    HW_RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({s_ready, m_valid, m_data, mem_debug, debug_func, debug_we, debug_re,
         addr, din, busy, err} !== '0) begin
      errors++;
      $display("FAIL reset_values got ready=%b mv=%b md=%h md=%b fn=%h we=%b re=%b a=%h d=%h busy=%b err=%b expected=all 0",
               s_ready, m_valid, m_data, mem_debug, debug_func, debug_we, debug_re, addr, din, busy, err);
    end
    sync();
    HW_RSTn = 1'b1;
    @(negedge CLK);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_first_clock got=%b expected=0", s_ready);
    end
    @(negedge CLK);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_first_clock got=%b expected=1", s_ready);
    end
    sync();
  endtask

  task automatic test_write_im();
    wr_data = {32'h2008000A, 32'h20090005};
    do_write(2'b00, 32'h0, 8'd2);
    wait_drain("write_im");
    checks++;
    if ({mem_debug, debug_func} !== 3'b1_00) begin
      errors++;
      $display("FAIL write_im_mem_debug got=%b/%b expected=1/00", mem_debug, debug_func);
    end
  endtask

  task automatic test_read_im();
    int base;
    base = re_cnt;
    do_read(2'b00, 32'h0, 8'd2);
    wait_drain("read_im");
    checks++;
    if (re_cnt - base != 2) begin
      errors++;
      $display("FAIL read_im_re_count got=%0d expected=2", re_cnt - base);
    end
  endtask

  task automatic test_read_mr_and_wrap();
    do_read(2'b10, 32'h1F, 8'd2);
    wait_drain("read_mr");
    checks++;
    if (debug_func !== 2'b10) begin
      errors++;
      $display("FAIL read_mr_func got=%b expected=10", debug_func);
    end
    wr_data = {32'hDEADBEEF, 32'h01234567};
    do_write(2'b01, 32'hFFFF_FFFC, 8'd2);
    wait_drain("write_wrap");
    do_read(2'b01, 32'hFFFF_FFFC, 8'd2);
    wait_drain("read_wrap");
  endtask

  task automatic test_illegal_release();
    int          e0, w0, r0;
    logic [31:0] a0;
    e0 = err_cnt; w0 = we_cnt; r0 = re_cnt; a0 = addr;
    send_byte(8'hC0);
    send_byte(8'h30);
    repeat (3) sync();
    checks++;
    if (err_cnt - e0 != 2) begin
      errors++;
      $display("FAIL illegal_err_pulses got=%0d expected=2", err_cnt - e0);
    end
    checks++;
    if ({we_cnt - w0, re_cnt - r0} !== 64'd0) begin
      errors++;
      $display("FAIL illegal_strobes got we=%0d re=%0d expected=0/0", we_cnt - w0, re_cnt - r0);
    end
    checks++;
    if ({busy, mem_debug, addr} !== {1'b0, 1'b1, a0}) begin
      errors++;
      $display("FAIL illegal_state got busy=%b md=%b addr=%h expected busy=0 md=1 addr=%h",
               busy, mem_debug, addr, a0);
    end
    send_byte(8'h80);
    sync();
    checks++;
    if ({mem_debug, debug_func, debug_we, debug_re, addr, din} !== '0) begin
      errors++;
      $display("FAIL release_outputs got md=%b fn=%b we=%b re=%b addr=%h din=%h expected=all 0",
               mem_debug, debug_func, debug_we, debug_re, addr, din);
    end
  endtask

  task automatic test_backpressure();
    int          base_b, base_r, t;
    logic [31:0] w0;
    w0     = ref_mem[{2'b00, 32'h0}];
    base_b = bytes_seen;
    do_read(2'b00, 32'h0, 8'd2);
    t = 0;
    while (bytes_seen < base_b + 2 && t < 200) begin
      sync();
      t++;
    end
    m_ready = 1'b0;
    base_r  = re_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks++;
      if ({m_valid, m_data} !== {1'b1, w0[23:16]}) begin
        errors++;
        $display("FAIL stall_hold cycle=%0d got mv=%b md=%h expected mv=1 md=%h",
                 i, m_valid, m_data, w0[23:16]);
      end
    end
    sync();
    checks++;
    if (re_cnt != base_r) begin
      errors++;
      $display("FAIL stall_extra_re got=%0d expected=0", re_cnt - base_r);
    end
    m_ready = 1'b1;
    wait_drain("backpressure");
  endtask

  task automatic test_count_zero();
    int base;
    wr_data.delete();
    for (int i = 0; i < 256; i++) wr_data.push_back($urandom);
    do_write(2'b00, 32'h1000, 8'd0);
    wait_drain("write_n0");
    base = re_cnt;
    do_read(2'b00, 32'h1000, 8'd0);
    wait_drain("read_n0");
    checks++;
    if (re_cnt - base != 256) begin
      errors++;
      $display("FAIL n0_read_count got=%0d expected=256", re_cnt - base);
    end
  endtask

  task automatic test_reset_mid_burst();
    send_cmd(8'h00, 32'h40, 8'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    HW_RSTn = 1'b0;
    #1;
    checks++;
    if ({s_ready, m_valid, m_data, mem_debug, debug_func, debug_we, debug_re,
         addr, din, busy, err} !== '0) begin
      errors++;
      $display("FAIL reset_mid_values got ready=%b md=%b fn=%h a=%h d=%h busy=%b expected=all 0",
               s_ready, mem_debug, debug_func, addr, din, busy);
    end
    repeat (3) sync();
    HW_RSTn = 1'b1;
    repeat (20) sync();
    checks++;
    if ({s_ready, busy, mem_debug} !== 3'b100) begin
      errors++;
      $display("FAIL reset_mid_after got ready=%b busy=%b md=%b expected 1/0/0",
               s_ready, busy, mem_debug);
    end
    wr_data = {32'hCAFEF00D};
    do_write(2'b00, 32'h40, 8'd1);
    wait_drain("fresh_write");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_im();
    test_read_im();
    test_read_mr_and_wrap();
    test_illegal_release();
    test_backpressure();
    test_count_zero();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpa_debug_bridge.md
# mpa_debug_bridge

Byte-stream-to-debug-port bridge that sits directly upstream of `mpa_mips_32` and drives its memory debug port (`mem_debug`, `debug_func`, `debug_we`, `debug_re`, `addr`, `din`, `dout`). It parses a simple command stream from a host (UART or bench), performs burst writes and reads into IM, DM or MR, and returns read data as a byte stream. It replaces bench-driven debug tasks and serves as the program loader.

## Interface
Parameters:
- `DATA_WIDTH`, 32: debug data width; must be a multiple of 8. `NB = DATA_WIDTH/8` bytes per word.
- `ADDRESS_WIDTH`, 32: debug address width; ≤ 32.

Ports:
- `CLK`  in  1  single clock; all logic is on the rising edge.
- `HW_RSTn`  in  1  asynchronous, active-low reset.
- `s_valid`, `s_data[7:0]`, `s_ready`  in, in, out  command byte stream; a byte transfers when `s_valid && s_ready`.
- `m_valid`, `m_data[7:0]`, `m_ready`  out, out, in  response byte stream; `m_valid`/`m_data` hold until `m_ready`.
- `mem_debug`, `debug_func[1:0]`, `debug_we`, `debug_re`  out  debug controls to the core.
- `addr[ADDRESS_WIDTH-1:0]`, `din[DATA_WIDTH-1:0]`  out  debug address and write data.
- `dout[DATA_WIDTH-1:0]`  in  debug read data from the core.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  one-cycle pulse when an illegal header is dropped.

## Operation
- Header byte: [7:6] op (00 WRITE, 01 READ, 10 RELEASE, 11 illegal); [5:4] func (00 IM, 01 DM, 10 MR, 11 illegal); [3:0] ignored.
- WRITE/READ: header, then 4 address bytes (LSB first; truncated to ADDRESS_WIDTH), then 1 count byte N (words; 0 means 256). WRITE then carries N×NB data bytes, LSB first.
- Address step: +4 for IM/DM (byte-addressed), +1 for MR (word-addressed). Address wraps modulo 2^ADDRESS_WIDTH.
- On WRITE/READ acceptance: `mem_debug`←1 and `debug_func`←func. Both stay asserted after the burst until a RELEASE is processed.
- RELEASE: `mem_debug`, `debug_we`, `debug_re`, `debug_func`, `addr` and `din` all go to 0. It is a no-op when `mem_debug` is already 0.
- Illegal op or func: pulse `err`, discard the header only, stay in IDLE, and leave the debug outputs unchanged.
- States: IDLE → ADDR (4 bytes) → CNT → WDAT (NB bytes) → WSTB → (WDAT or IDLE); CNT → RREQ → RCAP → RSND (NB bytes) → (RREQ or IDLE). RELEASE goes IDLE → IDLE.
- WSTB: `debug_we`=1 for exactly one cycle, with `addr`/`din` stable and `debug_re`=0. Address and word counter advance on exit.
- RREQ: `debug_re`=1 for one cycle with `addr` stable. RCAP: `dout` is registered one cycle after RREQ. RSND: bytes emitted LSB first.
- `s_ready`=1 only in IDLE, ADDR, CNT and WDAT. `m_valid`=1 only in RSND.
- `debug_we` and `debug_re` are never high together.

## Timing
- Reset values: `s_ready`=0, `m_valid`=0, `m_data`=0, `mem_debug`=0, `debug_func`=0, `debug_we`=0, `debug_re`=0, `addr`=0, `din`=0, `busy`=0, `err`=0. State is IDLE; `s_ready` rises on the first clock after reset release.
- Write word: NB accepted bytes, then 1 strobe cycle. At full throughput each word costs NB+1 cycles.
- Read word: RREQ (1 cycle) + RCAP (1 cycle) + NB bytes with `m_ready` held high. The first `m_valid` appears 2 cycles after the RREQ entry edge.
- Back-pressure: `m_ready`=0 stalls in RSND with `m_data` held. `s_valid`=0 stalls parsing indefinitely; there is no timeout.
- Reset asserted mid-burst: all outputs take reset values immediately; partial words and counts are discarded; core sees `mem_debug` drop.

## Structure
- Package `mpa_dbg_pkg`: op codes, func codes, state enum, `ADDR_STEP_BYTE`=4, `ADDR_STEP_WORD`=1, `ADDR_BYTES`=4.
- Sub-module `mpa_dbg_byte_shifter`: NB-byte shift register that loads bytes LSB-first (assemble) or parallel-loads a word and shifts bytes out (serialize). It has a byte counter with a done flag and is used by both WDAT and RSND.
- Top FSM, address and word counters live in `mpa_debug_bridge`.

## Test plan
- Reset, then WRITE IM addr 0x0 N=2 with data 0x2008000A and 0x20090005. Require `debug_we` pulses at `addr`=0 and `addr`=4 with those `din` values, and `mem_debug`=1 after the burst.
- READ IM addr 0x0 N=2 with the core model returning the written words. Require `m_data` sequence 0A 00 08 20 05 00 09 20, and `debug_re` high exactly 2 single cycles.
- READ MR addr 0x1F N=2. Require `addr`=0x1F then 0x20 (step 1). WRITE DM addr 0xFFFFFFFC N=2; require `addr` 0xFFFFFFFC then 0x00000000 (wrap).
- Header 0xC0 then 0x30. Require two `err` pulses, no `debug_we`/`debug_re`, and state IDLE. A following RELEASE 0x80 drives all debug outputs to 0.
- READ with `m_ready` low for 10 cycles mid-word. Require `m_data` stable and no extra `debug_re`. N=0 yields 256 reads.
- Assert `HW_RSTn`=0 after the 2nd data byte of a WRITE. Require all outputs at reset values at once, and no `debug_we` after release until a fresh command.
